// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB first through one full-adder
// stage with a registered carry, and the sum is collected into a shift register.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    logic             bit_sum;
    logic             bit_carry;

    assign bit_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign bit_carry = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        s_sh_d      = s_sh_q;
        sum_d       = sum_q;
        count_d     = count_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = bit_carry;
                s_sh_d  = {bit_sum, s_sh_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                // The final bit is folded straight into the output register here.
                if (count_q == LAST) begin
                    sum_d       = {bit_sum, s_sh_q[WIDTH-1:1]};
                    cout_d      = bit_carry;
                    out_valid_d = 1'b1;
                    count_d     = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            s_sh_q      <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            s_sh_q      <= s_sh_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: stimulus pushes a+b+cin into a scoreboard,
// and a monitor pops and compares each time a result appears.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] exp_q[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [WIDTH:0] refAdd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Monitor: every rising edge of out_valid must match the oldest queued result.
    initial begin
        logic           prev;
        logic [WIDTH:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && out_valid === 1'b1 && !prev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("scoreboard_result", 32'({cout, sum}), 32'(e));
                end
            end
            prev = (out_valid === 1'b1);
        end
    end

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                 input logic op_cin, input int hold);
        bit             ok;
        int             lat;
        logic [WIDTH:0] expv;
        expv = refAdd(op_a, op_b, op_cin);
        waitReady(ok);
        if (!ok) begin
            checkOutput("in_ready_timeout", 32'(0), 32'(1));
            return;
        end
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(WIDTH));
        // Hold the result while offering new operands that must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", 32'(out_valid), 32'(1));
            checkOutput("bp_in_ready", 32'(in_ready), 32'(0));
            checkOutput("bp_result", 32'({cout, sum}), 32'(expv));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("handoff_out_valid", 32'(out_valid), 32'(0));
        checkOutput("handoff_in_ready", 32'(in_ready), 32'(1));
        checkOutput("held_after_handoff", 32'({cout, sum}), 32'(expv));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'(1));
        checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset_result", 32'({cout, sum}), 32'(0));

        applyStimulus(8'h00, 8'h00, 1'b0, 0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus({7'd0, i[0]}, {7'd0, i[1]}, i[2], 0);
        end
        applyStimulus(8'hA5, 8'h5A, 1'b1, 0);
        applyStimulus(8'h7F, 8'h80, 1'b0, 5);

        // Abort an operation mid-flight; no result may ever appear for it.
        waitReady(ok);
        checkOutput("abort_ready", 32'(ok), 32'(1));
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'h01;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'(1));
        checkOutput("abort_out_valid", 32'(out_valid), 32'(0));
        checkOutput("abort_result", 32'({cout, sum}), 32'(0));
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_valid", 32'(out_valid), 32'(0));
        end
        applyStimulus(8'h03, 8'h04, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
